mem_stage: RTL and testbench

//   MEM pipeline stage. Sits between exe_stage and wb_stage.
//   - Waits for the data-SRAM response of loads/stores issued in EXE.
//   - Aligns and extends load data.
//   - Drops responses that belong to instructions flushed by WB (exception, ertn, remap refetch).
//   - Drives the MS->WS handshake/bus and the MS->DS forward bus.

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_stage_ld_align.sv | 48 ++++
 rtl/mem_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the MEM pipeline stage:
//     - default bus widths (passthrough field, discard counter, forward bus)
//     - bit offsets of the fields MEM inspects or rewrites inside the
//       passthrough field
//     - load-type encoding and the EXE->MEM sideband layout
//     - small extension helpers used by the load aligner
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  // Default widths. MEM->WB passthrough is 206 bits. EXE->MEM adds a 7-bit
  // sideband on top of it.
  localparam int MS_PASS_WD  = 206;
  localparam int MS_DCNT_WD  = 2;
  localparam int MS_SIDE_WD  = 7;
  localparam int MS_FWD_WD   = 39;

  // Offsets inside the passthrough field. Every bit not listed here is
  // carried to WB untouched.
  localparam int PC_LSB      = 0;
  localparam int RESULT_LSB  = 32;
  localparam int DEST_LSB    = 64;
  localparam int GR_WE_BIT   = 69;
  localparam int EX_BIT      = 71;

  // Load width/sign selector carried in the sideband.
  typedef enum logic [2:0] {
    LD_TYPE_B  = 3'd0,
    LD_TYPE_BU = 3'd1,
    LD_TYPE_H  = 3'd2,
    LD_TYPE_HU = 3'd3,
    LD_TYPE_W  = 3'd4
  } ld_type_e;

  // Sideband sitting above the passthrough field in es_to_ms_bus:
  //   {mem_req, ld_en, ld_type[2:0], addr_lo[1:0]}
  typedef struct packed {
    logic       mem_req;
    logic       ld_en;
    logic [2:0] ld_type;
    logic [1:0] addr_lo;
  } ms_side_t;

  // Extend a byte to a word, sign-extending when sgn is set.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Extend a halfword to a word, sign-extending when sgn is set.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_ld_align.sv
// ---------------------------------------------------------------------------
// mem_ld_align
//   Combinational load-data aligner. Picks the addressed byte or halfword
//   out of the raw 32-bit SRAM word and sign- or zero-extends it according
//   to ld_type. Word loads (and any unused encoding) return the raw word.
//
// Ports
//   ld_type  in   3   load type (b, bu, h, hu, w)
//   addr_lo  in   2   low address bits of the access
//   raw      in   32  raw data word from the SRAM / skid buffer
//   result   out  32  aligned, extended load value
// ---------------------------------------------------------------------------
module mem_ld_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // Byte lanes of the raw word, indexed by addr_lo.
  logic [7:0]  raw_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign raw_bytes[gi] = raw[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = raw_bytes[addr_lo];
  // Halfword accesses are aligned, so only addr_lo[1] picks the half.
  assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    result = raw;
    case (ld_type)
      LD_TYPE_B:  result = ext_byte(byte_sel, 1'b1);
      LD_TYPE_BU: result = ext_byte(byte_sel, 1'b0);
      LD_TYPE_H:  result = ext_half(half_sel, 1'b1);
      LD_TYPE_HU: result = ext_half(half_sel, 1'b0);
      default:    result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage between EXE and WB.
//     - Holds one instruction and waits for the data-SRAM response of a
//       load/store issued in EXE.
//     - Keeps a one-entry skid buffer for a response that arrives while WB
//       is stalled.
//     - Counts responses still owed to instructions flushed by WB and
//       silently drops them when they arrive.
//     - Aligns/extends load data and writes it into the result field.
//     - Drives the MS->WS handshake and the MS->DS forward bus.
//
// Ports
//   clk                  in   1          clock
//   reset                in   1          synchronous, active-high
//   es_to_ms_valid       in   1          EXE holds a valid instruction
//   es_to_ms_bus         in   PASS_WD+7  {mem_req,ld_en,ld_type,addr_lo,pass}
//   ms_allowin           out  1          MEM can accept this cycle
//   ws_allowin           in   1          WB can accept this cycle
//   ws_cancel            in   1          WB flush
//   data_sram_data_ok    in   1          data response valid
//   data_sram_rdata      in   32         response data
//   ms_to_ws_valid       out  1          bundle valid towards WB
//   ms_to_ws_bus         out  PASS_WD    pass field, result possibly replaced
//   mem_result           out  32         aligned/extended load data
//   forward_ms_to_ds_bus out  39         {fwd_data,fwd_valid,fwd_block,dest}
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PASS_WD = MS_PASS_WD,
  parameter int DCNT_WD = MS_DCNT_WD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  input  logic [PASS_WD+6:0]   es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  input  logic                 ws_cancel,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic                 ms_to_ws_valid,
  output logic [PASS_WD-1:0]   ms_to_ws_bus,
  output logic [31:0]          mem_result,
  output logic [MS_FWD_WD-1:0] forward_ms_to_ds_bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                ms_valid_reg;
  logic [PASS_WD+6:0]  bus_reg;
  logic [31:0]         data_buf_reg;
  logic                data_buf_vld_reg;
  logic [DCNT_WD-1:0]  discard_cnt_reg;
  logic [DCNT_WD-1:0]  discard_cnt_next;

  // -------------------------------------------------------------------------
  // Field decode of the held bundle
  // -------------------------------------------------------------------------
  ms_side_t            side_r;
  logic [PASS_WD-1:0]  pass_r;
  logic                ex_r;
  logic                gr_we_r;
  logic [4:0]          dest_r;

  assign side_r  = bus_reg[PASS_WD +: MS_SIDE_WD];
  assign pass_r  = bus_reg[PASS_WD-1:0];
  assign ex_r    = pass_r[EX_BIT];
  assign gr_we_r = pass_r[GR_WE_BIT];
  assign dest_r  = pass_r[DEST_LSB +: 5];

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic        cnt_zero;
  logic        resp_ok;
  logic        wait_resp;
  logic        ms_ready_go;
  logic        accept;
  logic        capture;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] raw_data;

  assign cnt_zero = (discard_cnt_reg == '0);

  // A data_ok only belongs to the current instruction once every response
  // owed to flushed instructions has been drained.
  assign resp_ok = data_sram_data_ok & cnt_zero;

  // Excepting instructions never issued their request, and a buffered
  // response already satisfies the wait.
  assign wait_resp = ms_valid_reg & side_r.mem_req & ~ex_r & ~data_buf_vld_reg;

  // The response may be consumed in the very cycle it arrives.
  assign ms_ready_go = ~wait_resp | resp_ok;

  assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ws_allowin);
  assign accept         = es_to_ms_valid & ms_allowin & ~ws_cancel;
  assign ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~ws_cancel;

  // Response is here but WB will not take it this cycle: park it so the
  // live SRAM bus is free and no second response is expected.
  assign capture = resp_ok & wait_resp & ~(ms_to_ws_valid & ws_allowin);

  assign raw_data = data_buf_vld_reg ? data_buf_reg : data_sram_rdata;

  // -------------------------------------------------------------------------
  // Load alignment and outgoing bus
  // -------------------------------------------------------------------------
  mem_ld_align u_ld_align (
    .ld_type (side_r.ld_type),
    .addr_lo (side_r.addr_lo),
    .raw     (raw_data),
    .result  (mem_result)
  );

  always_comb begin
    ms_to_ws_bus = pass_r;
    if (side_r.ld_en) begin
      ms_to_ws_bus[RESULT_LSB +: 32] = mem_result;
    end
  end

  // -------------------------------------------------------------------------
  // Forward bus towards decode
  // -------------------------------------------------------------------------
  logic fwd_valid;
  logic fwd_block;

  assign fwd_valid = ms_valid_reg & gr_we_r & (dest_r != 5'd0);
  // A load whose data has not arrived yet cannot be forwarded; DS stalls.
  assign fwd_block = fwd_valid & side_r.ld_en & ~ms_ready_go;

  assign forward_ms_to_ds_bus = {ms_to_ws_bus[RESULT_LSB +: 32], fwd_valid, fwd_block, dest_r};

  // -------------------------------------------------------------------------
  // Discard counter
  //   inc: a flushed instruction still owes a response (and that response
  //        is not the one arriving right now).
  //   dec: a response arrives while stale responses are outstanding; it is
  //        dropped.
  //   Both in the same cycle leave the count unchanged. The count saturates
  //   rather than wrapping; exceeding its range means the pipeline issued
  //   more requests than it is built to track.
  // -------------------------------------------------------------------------
  assign cnt_inc = ws_cancel & wait_resp & ~resp_ok;
  assign cnt_dec = data_sram_data_ok & ~cnt_zero;

  always_comb begin
    discard_cnt_next = discard_cnt_reg;
    if (cnt_inc && !cnt_dec && !(&discard_cnt_reg)) begin
      discard_cnt_next = discard_cnt_reg + DCNT_WD'(1);
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt_next = discard_cnt_reg - DCNT_WD'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg <= 1'b0;
    end else if (ws_cancel) begin
      ms_valid_reg <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_reg <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_reg <= '0;
    end else if (accept) begin
      bus_reg <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_buf_reg     <= 32'd0;
      data_buf_vld_reg <= 1'b0;
    end else if (accept) begin
      data_buf_vld_reg <= 1'b0;
    end else if (capture) begin
      data_buf_reg     <= data_sram_rdata;
      data_buf_vld_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt_reg <= '0;
    end else begin
      discard_cnt_reg <= discard_cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int PW = MS_PASS_WD;

  logic              clk = 1'b0;
  logic              reset;
  logic              es_to_ms_valid;
  logic [PW+6:0]     es_to_ms_bus;
  logic              ms_allowin;
  logic              ws_allowin;
  logic              ws_cancel;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              ms_to_ws_valid;
  logic [PW-1:0]     ms_to_ws_bus;
  logic [31:0]       mem_result;
  logic [38:0]       forward_ms_to_ds_bus;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_allowin           (ms_allowin),
    .ws_allowin           (ws_allowin),
    .ws_cancel            (ws_cancel),
    .data_sram_data_ok    (data_sram_data_ok),
    .data_sram_rdata      (data_sram_rdata),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .mem_result           (mem_result),
    .forward_ms_to_ds_bus (forward_ms_to_ds_bus)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build an EXE->MEM bundle; untouched pass bits get a pc-derived pattern.
  function automatic logic [PW+6:0] mk(input logic mem_req, input logic ld_en,
                                       input logic [2:0] lt, input logic [1:0] al,
                                       input logic [31:0] pc, input logic [31:0] res,
                                       input logic [4:0] dest, input logic gr_we,
                                       input logic ex);
    logic [223:0]  pat;
    logic [PW-1:0] p;
    pat = {7{pc ^ 32'h5a5a_a5a5}};
    p = pat[PW-1:0];
    p[31:0]  = pc;
    p[63:32] = res;
    p[68:64] = dest;
    p[69]    = gr_we;
    p[71]    = ex;
    return {mem_req, ld_en, lt, al, p};
  endfunction

  function automatic logic [PW-1:0] with_result(input logic [PW+6:0] b, input logic [31:0] r);
    logic [PW-1:0] p;
    p = b[PW-1:0];
    p[63:32] = r;
    return p;
  endfunction

  // One clock: score any MS->WS handshake before the edge, then step.
  task automatic cycle();
    logic [PW-1:0] e;
    #1;
    if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", {{(PW-1){1'b0}}, ms_to_ws_valid}, '0);
      end else begin
        e = exp_q.pop_front();
        $display("WB txn pc=%08h result=%08h", ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]);
        chk("sb_ms_to_ws_bus", ms_to_ws_bus, e);
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [PW+6:0] b;

    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    ws_cancel = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ms_to_ws_valid", ms_to_ws_valid, 0);
    chk("rst_ms_allowin", ms_allowin, 1);
    chk("rst_fwd_valid_block", forward_ms_to_ds_bus[6:5], 0);
    chk("rst_discard_cnt", dut.discard_cnt_reg, 0);
    reset = 1'b0;

    // 1: ld.w, data_ok two cycles after accept
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0000, 32'h0000_00aa, 5'd5, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'h8765_4321));
    cycle();
    es_to_ms_valid = 1'b0;
    #1;
    chk("t1_wait_valid", ms_to_ws_valid, 0);
    chk("t1_wait_allowin", ms_allowin, 0);
    cycle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8765_4321;
    #1;
    chk("t1_valid_on_data_ok", ms_to_ws_valid, 1);
    chk("t1_mem_result", mem_result, 32'h8765_4321);
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    chk("t1_drained", ms_to_ws_valid, 0);

    // 2: ld.b then ld.bu at addr_lo=3, back to back
    b = mk(1, 1, LD_TYPE_B, 2'd3, 32'h1c00_0004, 32'h0, 5'd6, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'hFFFF_FF80));
    cycle();
    b = mk(1, 1, LD_TYPE_BU, 2'd3, 32'h1c00_0008, 32'h0, 5'd6, 1, 0);
    es_to_ms_bus = b;
    exp_q.push_back(with_result(b, 32'h0000_0080));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8012_3456;
    #1;
    chk("t2_ld_b", mem_result, 32'hFFFF_FF80);
    chk("t2_allowin_same_cycle", ms_allowin, 1);
    cycle();
    es_to_ms_valid = 1'b0; data_sram_rdata = 32'h80AB_CDEF;
    #1;
    chk("t2_ld_bu", mem_result, 32'h0000_0080);
    cycle();
    data_sram_data_ok = 1'b0;

    // 3: ld.hu at addr_lo=2, forward block while waiting
    b = mk(1, 1, LD_TYPE_HU, 2'd2, 32'h1c00_0010, 32'h0, 5'd7, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'h0000_BEEF));
    cycle();
    es_to_ms_valid = 1'b0;
    #1;
    chk("t3_fwd_block", forward_ms_to_ds_bus[5], 1);
    chk("t3_fwd_valid", forward_ms_to_ds_bus[6], 1);
    chk("t3_fwd_dest", forward_ms_to_ds_bus[4:0], 7);
    cycle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_1234;
    #1;
    chk("t3_ld_hu", mem_result, 32'h0000_BEEF);
    chk("t3_fwd_unblock", forward_ms_to_ds_bus[5], 0);
    chk("t3_fwd_data", forward_ms_to_ds_bus[38:7], 32'h0000_BEEF);
    cycle();
    data_sram_data_ok = 1'b0;

    // 4: cancel while waiting, stale response dropped, new load delivered
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0014, 32'h0, 5'd8, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    cycle();
    es_to_ms_valid = 1'b0; ws_cancel = 1'b1;
    #1;
    chk("t4_cancel_valid", ms_to_ws_valid, 0);
    cycle();
    ws_cancel = 1'b0;
    #1;
    chk("t4_cnt_one", dut.discard_cnt_reg, 1);
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0018, 32'h0, 5'd9, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'h1111_1111));
    cycle();
    es_to_ms_valid = 1'b0;
    cycle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t4_stale_dropped", ms_to_ws_valid, 0);
    cycle();
    data_sram_rdata = 32'h1111_1111;
    #1;
    chk("t4_cnt_zero", dut.discard_cnt_reg, 0);
    chk("t4_new_valid", ms_to_ws_valid, 1);
    cycle();
    data_sram_data_ok = 1'b0;

    // 5: WB stalled when data arrives, released two cycles later
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_001c, 32'h0, 5'd10, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'hCAFE_F00D));
    cycle();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("t5_valid_stalled", ms_to_ws_valid, 1);
    chk("t5_allowin_stalled", ms_allowin, 0);
    cycle();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1;
    chk("t5_buffered_result", mem_result, 32'hCAFE_F00D);
    chk("t5_still_valid", ms_to_ws_valid, 1);
    cycle();
    ws_allowin = 1'b1;
    #1;
    chk("t5_release_allowin", ms_allowin, 1);
    cycle();
    #1;
    chk("t5_no_second_wait", ms_to_ws_valid, 0);

    // 6: ex bundle with stale count; cancel/data_ok interactions
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0020, 32'h0, 5'd11, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    cycle();
    es_to_ms_valid = 1'b0; ws_cancel = 1'b1;
    cycle();
    ws_cancel = 1'b0;
    b = mk(1, 0, LD_TYPE_W, 2'd0, 32'h1c00_0024, 32'h00E1_E1E1, 5'd12, 1, 1);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(b[PW-1:0]);
    cycle();
    b = mk(1, 0, LD_TYPE_W, 2'd0, 32'h1c00_0028, 32'h00E2_E2E2, 5'd13, 1, 1);
    es_to_ms_bus = b;
    #1;
    chk("t6_ex_no_wait", ms_to_ws_valid, 1);
    chk("t6_cnt_still_one", dut.discard_cnt_reg, 1);
    cycle();
    es_to_ms_valid = 1'b0; ws_cancel = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_ex_cancelled", ms_to_ws_valid, 0);
    cycle();
    ws_cancel = 1'b0; data_sram_data_ok = 1'b0;
    #1;
    chk("t6_cnt_drained", dut.discard_cnt_reg, 0);
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_002c, 32'h0, 5'd14, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    cycle();
    es_to_ms_valid = 1'b0; ws_cancel = 1'b1;
    cycle();
    ws_cancel = 1'b0;
    #1;
    chk("t6_cnt_incremented", dut.discard_cnt_reg, 1);
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0030, 32'h0, 5'd15, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    cycle();
    es_to_ms_valid = 1'b0; ws_cancel = 1'b1; data_sram_data_ok = 1'b1;
    cycle();
    ws_cancel = 1'b0;
    #1;
    chk("t6_cnt_net_zero", dut.discard_cnt_reg, 1);
    chk("t6_stale_not_delivered", ms_to_ws_valid, 0);
    cycle();
    data_sram_data_ok = 1'b0;
    #1;
    chk("t6_cnt_final", dut.discard_cnt_reg, 0);

    // ld.h at addr_lo=2 after the flush traffic settles
    b = mk(1, 1, LD_TYPE_H, 2'd2, 32'h1c00_0034, 32'h0, 5'd16, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    exp_q.push_back(with_result(b, 32'hFFFF_8001));
    cycle();
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000;
    #1;
    chk("t7_ld_h", mem_result, 32'hFFFF_8001);
    cycle();
    data_sram_data_ok = 1'b0;

    // reset while a load is waiting
    b = mk(1, 1, LD_TYPE_W, 2'd0, 32'h1c00_0038, 32'h0, 5'd17, 1, 0);
    es_to_ms_bus = b; es_to_ms_valid = 1'b1;
    cycle();
    es_to_ms_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("rst2_ms_to_ws_valid", ms_to_ws_valid, 0);
    chk("rst2_fwd_valid", forward_ms_to_ds_bus[6], 0);
    chk("rst2_allowin", ms_allowin, 1);

    chk("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
